// File: rtl/pcs_autoneg_ctrl.sv
// Clause-37-style auto-negotiation controller for the 1000BASE-X PCS.
// Drives xmit, supplies the /C/ payload and qualifies partner config words.
module pcs_autoneg_ctrl #(
    parameter int unsigned LINK_TIMER = 1250000,
    parameter int unsigned TIMER_W    = 21
) (
    input  logic        GTX_CLK,
    input  logic        mr_main_reset,
    input  logic        mr_an_enable,
    input  logic        mr_restart_an,
    input  logic [15:0] mr_adv_ability,
    input  logic        code_sync_status,
    input  logic        rudi_config,
    input  logic        rudi_idle,
    input  logic        rudi_invalid,
    input  logic [15:0] rx_config_reg,
    output logic [1:0]  xmit,
    output logic [15:0] tx_config_reg,
    output logic        mr_an_complete,
    output logic        mr_page_rx,
    output logic [15:0] mr_lp_adv_ability,
    output logic [2:0]  an_state
);

    typedef enum logic [2:0] {
        AN_ENABLE            = 3'd0,
        AN_RESTART           = 3'd1,
        ABILITY_DETECT       = 3'd2,
        ACKNOWLEDGE_DETECT   = 3'd3,
        COMPLETE_ACKNOWLEDGE = 3'd4,
        IDLE_DETECT          = 3'd5,
        LINK_OK              = 3'd6,
        AN_DISABLE_LINK_OK   = 3'd7
    } an_state_e;

    localparam logic [1:0]         XMIT_CONFIG = 2'b00;
    localparam logic [1:0]         XMIT_IDLE   = 2'b01;
    localparam logic [1:0]         XMIT_DATA   = 2'b10;
    localparam logic [15:0]        ACK_BIT     = 16'h4000;
    localparam logic [15:0]        CMP_MASK    = 16'hBFFF;
    localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(LINK_TIMER - 1);

    an_state_e          state_q, state_d;
    logic [15:0]        held_q, held_n;
    logic [15:0]        abil_q;
    logic [1:0]         cfg_cnt_q, cfg_cnt_n;
    logic [1:0]         idle_cnt_q, idle_cnt_n;
    logic [TIMER_W-1:0] timer_q;
    logic [1:0]         xmit_q, xmit_d;
    logic [15:0]        tx_cfg_q, tx_cfg_d;
    logic               an_cmp_q, an_cmp_d;
    logic               page_rx_q, page_rx_d;
    logic [15:0]        lp_adv_q, lp_adv_d;

    logic cfg_ev, idle_ev;
    logic ability_match, acknowledge_match, zero_match, consistency_match, idle_match;
    logic timer_done, timer_load, force_enable;

    assign cfg_ev  = rudi_config & ~rudi_invalid;
    assign idle_ev = rudi_idle & ~rudi_config & ~rudi_invalid;

    // Matchers see this cycle's strobe so a qualifying word moves the FSM on the same edge.
    always_comb begin
        held_n     = held_q;
        cfg_cnt_n  = cfg_cnt_q;
        idle_cnt_n = idle_cnt_q;
        if (rudi_invalid) begin
            cfg_cnt_n  = 2'd0;
            idle_cnt_n = 2'd0;
        end else if (cfg_ev) begin
            held_n     = rx_config_reg;
            idle_cnt_n = 2'd0;
            if ((rx_config_reg & CMP_MASK) == (held_q & CMP_MASK))
                cfg_cnt_n = (cfg_cnt_q == 2'd3) ? 2'd3 : cfg_cnt_q + 2'd1;
            else
                cfg_cnt_n = 2'd1;
        end else if (idle_ev) begin
            cfg_cnt_n  = 2'd0;
            idle_cnt_n = (idle_cnt_q == 2'd3) ? 2'd3 : idle_cnt_q + 2'd1;
        end
    end

    assign ability_match     = (cfg_cnt_n == 2'd3);
    assign acknowledge_match = ability_match & held_n[14];
    assign zero_match        = ability_match & ((held_n & CMP_MASK) == 16'h0000);
    assign consistency_match = ((held_n & CMP_MASK) == (abil_q & CMP_MASK));
    assign idle_match        = (idle_cnt_n == 2'd3);
    assign timer_done        = (timer_q == TIMER_LAST);
    assign force_enable      = mr_restart_an | (~code_sync_status & mr_an_enable);

    always_comb begin
        state_d = state_q;
        if (force_enable) begin
            state_d = AN_ENABLE;
        end else begin
            case (state_q)
                AN_ENABLE:
                    state_d = mr_an_enable ? AN_RESTART : AN_DISABLE_LINK_OK;
                AN_RESTART:
                    if (timer_done) state_d = ABILITY_DETECT;
                ABILITY_DETECT:
                    if (rudi_invalid)                     state_d = AN_ENABLE;
                    else if (ability_match && !zero_match) state_d = ACKNOWLEDGE_DETECT;
                ACKNOWLEDGE_DETECT:
                    if (rudi_invalid)                                state_d = AN_ENABLE;
                    else if (acknowledge_match && consistency_match) state_d = COMPLETE_ACKNOWLEDGE;
                    else if (acknowledge_match || zero_match)        state_d = AN_ENABLE;
                COMPLETE_ACKNOWLEDGE:
                    if (rudi_invalid || zero_match) state_d = AN_ENABLE;
                    else if (timer_done)            state_d = IDLE_DETECT;
                IDLE_DETECT:
                    if (rudi_invalid || zero_match)    state_d = AN_ENABLE;
                    else if (timer_done && idle_match) state_d = LINK_OK;
                LINK_OK:
                    if (ability_match) state_d = AN_ENABLE;
                AN_DISABLE_LINK_OK:
                    if (mr_an_enable) state_d = AN_ENABLE;
                default:
                    state_d = AN_ENABLE;
            endcase
        end
    end

    assign timer_load = (state_d != state_q) &&
                        (state_d inside {AN_RESTART, COMPLETE_ACKNOWLEDGE, IDLE_DETECT});

    // Outputs are decoded from the next state and registered, so they line up with an_state.
    always_comb begin
        xmit_d    = XMIT_CONFIG;
        tx_cfg_d  = tx_cfg_q;
        an_cmp_d  = 1'b0;
        page_rx_d = page_rx_q;
        lp_adv_d  = lp_adv_q;
        case (state_d)
            AN_ENABLE: begin
                tx_cfg_d  = 16'h0000;
                page_rx_d = 1'b0;
            end
            AN_RESTART:         tx_cfg_d = 16'h0000;
            ABILITY_DETECT:     tx_cfg_d = mr_adv_ability & ~ACK_BIT;
            ACKNOWLEDGE_DETECT: tx_cfg_d = mr_adv_ability | ACK_BIT;
            COMPLETE_ACKNOWLEDGE: begin
                page_rx_d = 1'b1;
                if (state_q != COMPLETE_ACKNOWLEDGE) lp_adv_d = held_n;
            end
            IDLE_DETECT:        xmit_d = XMIT_IDLE;
            LINK_OK: begin
                xmit_d   = XMIT_DATA;
                an_cmp_d = 1'b1;
            end
            AN_DISABLE_LINK_OK: xmit_d = XMIT_DATA;
            default: ;
        endcase
    end

    always_ff @(posedge GTX_CLK) begin
        if (mr_main_reset) begin
            state_q    <= AN_ENABLE;
            held_q     <= 16'h0000;
            abil_q     <= 16'h0000;
            cfg_cnt_q  <= 2'd0;
            idle_cnt_q <= 2'd0;
            timer_q    <= '0;
            xmit_q     <= XMIT_CONFIG;
            tx_cfg_q   <= 16'h0000;
            an_cmp_q   <= 1'b0;
            page_rx_q  <= 1'b0;
            lp_adv_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            held_q  <= held_n;
            if (state_d != state_q) begin
                cfg_cnt_q  <= 2'd0;
                idle_cnt_q <= 2'd0;
            end else begin
                cfg_cnt_q  <= cfg_cnt_n;
                idle_cnt_q <= idle_cnt_n;
            end
            if (state_q == ABILITY_DETECT && state_d == ACKNOWLEDGE_DETECT)
                abil_q <= held_n;
            if (timer_load)
                timer_q <= '0;
            else if (!timer_done)
                timer_q <= timer_q + TIMER_W'(1);
            xmit_q    <= xmit_d;
            tx_cfg_q  <= tx_cfg_d;
            an_cmp_q  <= an_cmp_d;
            page_rx_q <= page_rx_d;
            lp_adv_q  <= lp_adv_d;
        end
    end

    assign xmit              = xmit_q;
    assign tx_config_reg     = tx_cfg_q;
    assign mr_an_complete    = an_cmp_q;
    assign mr_page_rx        = page_rx_q;
    assign mr_lp_adv_ability = lp_adv_q;
    assign an_state          = state_q;

endmodule

// File: tb/tb_pcs_autoneg_ctrl.sv
// Bench for pcs_autoneg_ctrl: directed handshakes plus random strobe bursts,
// scored each cycle against a strobe-history reference model.
module tb_pcs_autoneg_ctrl;

    localparam int LT = 16;

    logic        clk = 1'b0;
    logic        mr_main_reset = 1'b1;
    logic        mr_an_enable = 1'b1;
    logic        mr_restart_an = 1'b0;
    logic [15:0] mr_adv_ability = 16'h0000;
    logic        code_sync_status = 1'b1;
    logic        rudi_config = 1'b0;
    logic        rudi_idle = 1'b0;
    logic        rudi_invalid = 1'b0;
    logic [15:0] rx_config_reg = 16'h0000;
    logic [1:0]  xmit;
    logic [15:0] tx_config_reg;
    logic        mr_an_complete;
    logic        mr_page_rx;
    logic [15:0] mr_lp_adv_ability;
    logic [2:0]  an_state;

    always #5 clk = ~clk;

    pcs_autoneg_ctrl #(.LINK_TIMER(LT), .TIMER_W(21)) dut (
        .GTX_CLK(clk), .mr_main_reset(mr_main_reset), .mr_an_enable(mr_an_enable),
        .mr_restart_an(mr_restart_an), .mr_adv_ability(mr_adv_ability),
        .code_sync_status(code_sync_status), .rudi_config(rudi_config),
        .rudi_idle(rudi_idle), .rudi_invalid(rudi_invalid), .rx_config_reg(rx_config_reg),
        .xmit(xmit), .tx_config_reg(tx_config_reg), .mr_an_complete(mr_an_complete),
        .mr_page_rx(mr_page_rx), .mr_lp_adv_ability(mr_lp_adv_ability), .an_state(an_state)
    );

    typedef struct packed {
        logic [2:0]  st;
        logic [1:0]  xm;
        logic [15:0] tx;
        logic        cmp;
        logic        prx;
        logic [15:0] lp;
    } obs_t;

    obs_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    bit   seen[8];

    // Reference model: recent strobe history (config word, -1 idle, -2 invalid) since last state change.
    int          m_st;
    int          m_hist[$];
    int          m_t;
    logic [15:0] m_held, m_abil, m_tx, m_lp;
    logic        m_prx;
    logic        en_v = 1'b1;
    logic [15:0] adv_v = 16'h01A0;

    function automatic logic [15:0] msk(input logic [15:0] w);
        return w & 16'hBFFF;
    endfunction

    task automatic model_step();
        int nxt;
        bit abm, ackm, zm, cons, idm, tdone;
        obs_t e;
        if (mr_main_reset) begin
            m_st = 0; m_hist.delete(); m_t = 0;
            m_held = '0; m_abil = '0; m_tx = '0; m_lp = '0; m_prx = 1'b0;
            nxt = 0;
        end else begin
            if (rudi_invalid) m_hist.push_back(-2);
            else if (rudi_config) begin
                m_hist.push_back(int'(rx_config_reg));
                m_held = rx_config_reg;
            end else if (rudi_idle) m_hist.push_back(-1);
            while (m_hist.size() > 3) m_hist.delete(0);
            abm = 1'b0; idm = 1'b0;
            if (m_hist.size() == 3) begin
                abm = m_hist[0] >= 0 && m_hist[1] >= 0 && m_hist[2] >= 0 &&
                      msk(16'(m_hist[0])) == msk(16'(m_hist[2])) &&
                      msk(16'(m_hist[1])) == msk(16'(m_hist[2]));
                idm = m_hist[0] == -1 && m_hist[1] == -1 && m_hist[2] == -1;
            end
            ackm  = abm && m_held[14];
            zm    = abm && msk(m_held) == 16'h0000;
            cons  = msk(m_held) == msk(m_abil);
            tdone = m_t >= LT - 1;
            nxt = m_st;
            if (mr_restart_an || (!code_sync_status && mr_an_enable)) nxt = 0;
            else if (rudi_invalid && m_st >= 2 && m_st <= 5) nxt = 0;
            else case (m_st)
                0: nxt = mr_an_enable ? 1 : 7;
                1: if (tdone) nxt = 2;
                2: if (abm && !zm) nxt = 3;
                3: if (ackm && cons) nxt = 4; else if (ackm || zm) nxt = 0;
                4: if (zm) nxt = 0; else if (tdone) nxt = 5;
                5: if (zm) nxt = 0; else if (tdone && idm) nxt = 6;
                6: if (abm) nxt = 0;
                7: if (mr_an_enable) nxt = 0;
                default: nxt = 0;
            endcase
            if (m_st == 2 && nxt == 3) m_abil = m_held;
            if (nxt != m_st) begin
                if (nxt == 4) m_lp = m_held;
                m_hist.delete();
                m_t = 0;
            end else m_t++;
            case (nxt)
                0: begin m_tx = 16'h0000; m_prx = 1'b0; end
                1: m_tx = 16'h0000;
                2: m_tx = mr_adv_ability & 16'hBFFF;
                3: m_tx = mr_adv_ability | 16'h4000;
                4: m_prx = 1'b1;
                default: ;
            endcase
            m_st = nxt;
        end
        e.st  = 3'(nxt);
        e.xm  = (nxt == 5) ? 2'b01 : (nxt >= 6) ? 2'b10 : 2'b00;
        e.tx  = m_tx;
        e.cmp = (nxt == 6);
        e.prx = m_prx;
        e.lp  = m_lp;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit rst, input bit rs, input bit sy, input bit c,
                        input bit i, input bit v, input logic [15:0] w);
        @(negedge clk);
        mr_main_reset = rst; mr_an_enable = en_v; mr_restart_an = rs;
        mr_adv_ability = adv_v; code_sync_status = sy;
        rudi_config = c; rudi_idle = i; rudi_invalid = v; rx_config_reg = w;
        model_step();
    endtask

    task automatic quiet(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 1, 0, 0, 0, 16'h0);
    endtask

    task automatic cfgs(input logic [15:0] w, input int n);
        for (int k = 0; k < n; k++) step(0, 0, 1, 1, 0, 0, w);
    endtask

    task automatic idles(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 1, 0, 1, 0, 16'h0);
    endtask

    task automatic do_reset(input bit en_after);
        for (int k = 0; k < 2; k++) begin
            en_v = 1'($urandom); 
            step(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 16'($urandom));
        end
        en_v = en_after;
    endtask

    task automatic to_ability();
        do_reset(1'b1);
        quiet(LT + 2);
    endtask

    task automatic to_link_ok();
        to_ability();
        cfgs(adv_v, 3);
        cfgs(adv_v | 16'h4000, 3);
        quiet(LT + 1);
        quiet(LT);
        idles(3);
        quiet(3);
    endtask

    // Monitor: one expected observation per clock, popped just after the edge.
    initial begin
        int cyc = 0;
        obs_t e, g;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = '{st: an_state, xm: xmit, tx: tx_config_reg, cmp: mr_an_complete,
                      prx: mr_page_rx, lp: mr_lp_adv_ability};
                seen[an_state] = 1'b1;
                checks++;
                if (g === e) passes++;
                else $display("FAIL obs cyc=%0d got st=%0d xmit=%b tx=%h cmp=%b prx=%b lp=%h exp st=%0d xmit=%b tx=%h cmp=%b prx=%b lp=%h",
                              cyc, g.st, g.xm, g.tx, g.cmp, g.prx, g.lp, e.st, e.xm, e.tx, e.cmp, e.prx, e.lp);
            end
        end
    end

    initial begin
        int nb, act, len;
        logic [15:0] w, partner;

        // Reset and full handshake
        adv_v = 16'h01A0;
        to_link_ok();

        // Restart pulse and sync loss while in LINK_OK
        step(0, 1, 1, 0, 0, 0, 16'h0);
        quiet(3);
        to_link_ok();
        step(0, 0, 0, 0, 0, 0, 16'h0);
        quiet(3);

        // Inconsistent acknowledge
        to_ability();
        cfgs(16'h01A0, 3);
        cfgs(16'h4020, 3);
        quiet(3);

        // Disabled negotiation, then enable
        do_reset(1'b0);
        quiet(4);
        en_v = 1'b1;
        quiet(4);

        // Strobe collision, then an interrupted config run
        to_ability();
        step(0, 0, 1, 1, 0, 1, 16'h01A0);
        quiet(2);
        to_ability();
        cfgs(16'h01A0, 2);
        idles(1);
        cfgs(16'h01A0, 1);
        quiet(2);
        cfgs(16'h01A0, 2);
        quiet(2);

        // Zero page from partner while acknowledging
        to_ability();
        cfgs(16'h01A0, 3);
        cfgs(16'h0000, 3);
        quiet(2);

        // Random bursts around a partner word
        nb = 0;
        while (nb < 1500) begin
            nb++;
            if ($urandom_range(0, 49) == 0) adv_v = 16'($urandom);
            partner = ($urandom_range(0, 1) == 0) ? adv_v : 16'h0C21;
            act = $urandom_range(0, 11);
            len = $urandom_range(1, 5);
            case ($urandom_range(0, 7))
                0, 1, 2: w = partner;
                3, 4:    w = partner | 16'h4000;
                5:       w = 16'h0000;
                6:       w = 16'h4000;
                default: w = 16'($urandom);
            endcase
            if ($urandom_range(0, 199) == 0) en_v = ~en_v;
            if (!en_v && $urandom_range(0, 9) == 0) en_v = 1'b1;
            for (int k = 0; k < len; k++) begin
                bit rst, rs, sy;
                rst = ($urandom_range(0, 999) == 0);
                rs  = ($urandom_range(0, 299) == 0);
                sy  = ($urandom_range(0, 199) != 0);
                case (act)
                    0, 1, 2, 3: step(rst, rs, sy, 1, 0, 0, w);
                    4, 5:       step(rst, rs, sy, 0, 1, 0, w);
                    6:          step(rst, rs, sy, 0, 0, 1, w);
                    7:          step(rst, rs, sy, 1, 1, 0, w);
                    8:          step(rst, rs, sy, 1, 0, ($urandom_range(0, 3) == 0), w);
                    9:          step(rst, rs, sy, 0, 1, ($urandom_range(0, 3) == 0), w);
                    default:    step(rst, rs, sy, 0, 0, 0, w);
                endcase
            end
        end

        quiet(2);
        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
        for (int s = 0; s < 8; s++) begin
            checks++;
            if (seen[s]) passes++;
            else $display("FAIL state_reached state=%0d seen=0 required=1", s);
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pcs_autoneg_ctrl.md
Name: pcs_autoneg_ctrl

Overview:
Clause-37-style auto-negotiation controller for the 1000BASE-X PCS. It sequences the transmit path through CONFIGURATION, IDLE and DATA by driving xmit. It supplies the /C/ ordered-set payload (tx_config_reg) and qualifies link-partner config words delivered by the receive path. It sits above transmit, synchronization and receive, and owns the link-up decision.

Parameters:
LINK_TIMER, 1250000, link_timer duration in GTX_CLK cycles (10 ms at 125 MHz); benches override it to 16.
TIMER_W, 21, link timer counter width; must hold LINK_TIMER.

Ports:
GTX_CLK  input  1  single clock; all logic on rising edge.
mr_main_reset  input  1  synchronous, active-high reset.
mr_an_enable  input  1  1 = auto-negotiation enabled.
mr_restart_an  input  1  level; 1 forces AN_ENABLE while held.
mr_adv_ability  input  16  local advertised ability; bit 14 is ignored (controller owns ACK).
code_sync_status  input  1  from synchronization; 0 = sync lost.
rudi_config  input  1  1-cycle strobe: a /C/ word was received, value on rx_config_reg.
rudi_idle  input  1  1-cycle strobe: /I/ received.
rudi_invalid  input  1  1-cycle strobe: invalid ordered set.
rx_config_reg  input  16  partner config word, valid only with rudi_config.
xmit  output  2  00 CONFIGURATION, 01 IDLE, 10 DATA; 11 never driven.
tx_config_reg  output  16  config word for transmit to encode.
mr_an_complete  output  1  negotiation complete.
mr_page_rx  output  1  partner page received.
mr_lp_adv_ability  output  16  latched partner ability (ACK bit included).
an_state  output  3  current state code, for debug.

Behaviour:
- All outputs are registered Moore outputs of state. Effect is visible the cycle after the qualifying input.
- Reset values: state AN_ENABLE(0), xmit=00, tx_config_reg=0, mr_an_complete=0, mr_page_rx=0, mr_lp_adv_ability=0, timer=0, match counters=0.
- Strobe priority when several are asserted in one cycle: rudi_invalid > rudi_config > rudi_idle. Lower-priority strobes are ignored.
- Match logic (all matchers clear on every state change):
  - cfg_cnt saturates at 3. On rudi_config: if rx_config_reg[13:0,15] equals the held word, cfg_cnt++; otherwise hold the new word and set cfg_cnt=1. rudi_idle or rudi_invalid clears cfg_cnt.
  - ability_match = cfg_cnt==3.
  - acknowledge_match = ability_match and held bit14=1.
  - zero_match = ability_match and held word==0 (ignoring bit14).
  - consistency_match = held word (ignoring bit14) equals the word latched at ABILITY_DETECT exit.
  - idle_cnt saturates at 3, increments on rudi_idle, clears on rudi_config or rudi_invalid. idle_match = idle_cnt==3.
- Link timer: loads 0 on entry to AN_RESTART, COMPLETE_ACKNOWLEDGE and IDLE_DETECT, then counts up. timer_done is 1 when count reaches LINK_TIMER-1 and holds until the next load.
- Global override (highest priority after reset): mr_restart_an=1, or code_sync_status=0 while mr_an_enable=1, forces next state AN_ENABLE from any state.
- States and transitions:
  - AN_ENABLE(0): xmit=00, page_rx=0, an_complete=0. Next is AN_RESTART if mr_an_enable=1, else AN_DISABLE_LINK_OK.
  - AN_RESTART(1): tx_config_reg=0, xmit=00. On timer_done go to ABILITY_DETECT.
  - ABILITY_DETECT(2): tx_config_reg = mr_adv_ability with bit14=0. On ability_match and not zero_match, latch the held word and go to ACKNOWLEDGE_DETECT.
  - ACKNOWLEDGE_DETECT(3): tx_config_reg bit14=1. acknowledge_match and consistency_match go to COMPLETE_ACKNOWLEDGE. acknowledge_match and not consistency_match go to AN_ENABLE. zero_match goes to AN_ENABLE.
  - COMPLETE_ACKNOWLEDGE(4): mr_page_rx=1, mr_lp_adv_ability = held word. zero_match goes to AN_ENABLE; otherwise timer_done goes to IDLE_DETECT.
  - IDLE_DETECT(5): xmit=01. zero_match goes to AN_ENABLE; otherwise timer_done and idle_match go to LINK_OK.
  - LINK_OK(6): xmit=10, mr_an_complete=1. ability_match (partner restarted) goes to AN_ENABLE.
  - AN_DISABLE_LINK_OK(7): xmit=10, an_complete=0. mr_an_enable=1 goes to AN_ENABLE.
- rudi_invalid in states 2–5 goes to AN_ENABLE next cycle.
- mr_main_reset asserted mid-negotiation returns everything to reset values next edge, regardless of other inputs.

Test Plan:
- Reset: hold mr_main_reset 2 cycles with random inputs -> next cycle xmit=00, tx_config_reg=0000, an_state=0, all mr_* flags 0.
- Full handshake, LINK_TIMER=16, adv=0x01A0: AN_RESTART lasts 16 cycles with tx_config_reg=0. Send 3× rx 0x01A0 -> state 3, tx_config_reg=0x41A0. Send 3× 0x41A0 -> state 4, lp_adv=0x41A0, page_rx=1. After 16 cycles -> state 5, xmit=01. Send 3 idles after timer -> state 6, xmit=10, an_complete=1.
- Inconsistency: in state 3, send 3× 0x4020 after ability 0x01A0 -> state 0, then 1.
- Disable: mr_an_enable=0 after reset -> state 7, xmit=10. Raise enable -> state 0 then 1.
- Restart/sync loss: in LINK_OK, pulse mr_restart_an 1 cycle -> state 0, an_complete=0. Repeat with code_sync_status=0 -> same result.
- Strobe collision: in state 2, rudi_config+rudi_invalid in the same cycle -> state 0. A config word interrupted by an idle (C,C,I,C) must not trigger ability_match.
